// File: rtl/wavetable_interp_seq_if.sv
// rtl/wavetable_interp_seq_if.sv - wavetable memory read port and output sample handshake
//
// Purpose: bundles the table RAM read port and the downstream valid/ready sample
// stream of wavetable_interp_seq.
// Signals:
//   o_mem_rd / o_mem_addr : table read strobe and address (sequencer -> RAM)
//   i_mem_data            : signed read data, valid one cycle after o_mem_rd
//   o_sample / o_valid    : registered interpolated sample and its valid flag
//   i_ready               : downstream accept; transfer when o_valid && i_ready
// Modports: master = sequencer side, slave = RAM/downstream side.
interface wavetable_interp_seq_if #(
    parameter int WIDTH     = 8,
    parameter int PRECISION = 16,
    parameter int ADDR_W    = 4
);
    logic                           o_mem_rd;
    logic [ADDR_W-1:0]              o_mem_addr;
    logic signed [WIDTH-1:0]        i_mem_data;
    logic [WIDTH+PRECISION-1:0]     o_sample;
    logic                           o_valid;
    logic                           i_ready;

    modport master (
        output o_mem_rd, o_mem_addr, o_sample, o_valid,
        input  i_mem_data, i_ready
    );

    modport slave (
        input  o_mem_rd, o_mem_addr, o_sample, o_valid,
        output i_mem_data, i_ready
    );
endinterface

// File: rtl/wavetable_interp_seq.sv
// rtl/wavetable_interp_seq.sv - wavetable fetch/interpolate sequencer with phase accumulator
//
// Purpose: a phase accumulator picks table entries idx and idx+1 plus a fractional
// control word; the block fetches both samples, presents them to an external
// combinational interpolator, registers the result and delivers it on valid/ready.
// Ports:
//   i_clk, i_rst_n             : clock, synchronous active-low reset
//   i_en                       : run continuously while high
//   i_phase_inc                : phase step, applied when the sample is interpolated
//   i_phase_load, i_phase_init : one-cycle phase load strobe and value
//   bus                        : memory read port and output sample stream (master)
//   o_lin_low/high/ctrl        : interpolator operands (table[idx], table[idx+1], frac)
//   i_lin_out                  : interpolator result
//   o_busy                     : sequencer not idle
module wavetable_interp_seq #(
    parameter int WIDTH     = 8,
    parameter int PRECISION = 16,
    parameter int ADDR_W    = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_en,
    input  logic [ADDR_W+PRECISION-1:0]     i_phase_inc,
    input  logic                            i_phase_load,
    input  logic [ADDR_W+PRECISION-1:0]     i_phase_init,
    wavetable_interp_seq_if.master          bus,
    output logic signed [WIDTH-1:0]         o_lin_low,
    output logic signed [WIDTH-1:0]         o_lin_high,
    output logic [PRECISION-1:0]            o_lin_ctrl,
    input  logic [WIDTH+PRECISION-1:0]      i_lin_out,
    output logic                            o_busy
);
    localparam int PHASE_W = ADDR_W + PRECISION;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_LO = 3'd1,
        FETCH_HI = 3'd2,
        WAIT_HI  = 3'd3,
        INTERP   = 3'd4,
        OUT      = 3'd5
    } state_t;

    state_t                     state_q, state_d;
    logic [PHASE_W-1:0]         phase_q, phase_d;
    logic signed [WIDTH-1:0]    low_q, low_d;
    logic signed [WIDTH-1:0]    high_q, high_d;
    logic [WIDTH+PRECISION-1:0] sample_q, sample_d;
    logic                       valid_q, valid_d;
    logic                       mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]          mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0]          idx_next;

    // Index taken from the next phase so a load coinciding with entry into
    // FETCH_LO already addresses the newly loaded position.
    assign idx_next = phase_d[PHASE_W-1:PRECISION];

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        low_d      = low_q;
        high_d     = high_q;
        sample_d   = sample_q;
        valid_d    = valid_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;

        case (state_q)
            IDLE:     if (i_en) state_d = FETCH_LO;
            FETCH_LO: state_d = FETCH_HI;
            FETCH_HI: begin
                low_d   = bus.i_mem_data;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                high_d  = bus.i_mem_data;
                state_d = INTERP;
            end
            INTERP: begin
                sample_d = i_lin_out;
                valid_d  = 1'b1;
                phase_d  = phase_q + i_phase_inc;
                state_d  = OUT;
            end
            OUT: begin
                if (bus.i_ready) begin
                    valid_d = 1'b0;
                    state_d = i_en ? FETCH_LO : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A load always wins. While a sample is being assembled it is thrown
        // away; in IDLE/OUT only the phase changes and any pending sample stays.
        if (i_phase_load) begin
            phase_d = i_phase_init;
            if (state_q inside {FETCH_LO, FETCH_HI, WAIT_HI, INTERP}) begin
                low_d    = low_q;
                high_d   = high_q;
                sample_d = sample_q;
                valid_d  = valid_q;
                state_d  = i_en ? FETCH_LO : IDLE;
            end
        end

        // Read strobe/address are registered against the state being entered.
        if (state_d == FETCH_LO) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = idx_next;
        end else if (state_d == FETCH_HI) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = ADDR_W'(idx_next + 1'b1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            low_q      <= '0;
            high_q     <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            low_q      <= low_d;
            high_q     <= high_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.o_mem_rd   = mem_rd_q;
    assign bus.o_mem_addr = mem_addr_q;
    assign bus.o_sample   = sample_q;
    assign bus.o_valid    = valid_q;
    assign o_lin_low      = low_q;
    assign o_lin_high     = high_q;
    assign o_lin_ctrl     = phase_q[PRECISION-1:0];
    assign o_busy         = (state_q != IDLE);
endmodule
